// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: default sizes and FSM state encoding.
package alu_cmd_sequencer_pkg;

  localparam int unsigned DefW     = 4;
  localparam int unsigned DefSelW  = 4;
  localparam int unsigned DefDepth = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StHold  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: synchronous push/pop, count-based full/empty, sync flush, async reset.
// Storage is not reset; only pointers and count are.
module alu_cmd_fifo #(
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push_en, pop_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // Flush discards any handshake in the same cycle.
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && !empty && !flush;

  // Next count from the push/pop pair; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage write; no reset on data.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 4-bit ALU: queues commands, drives the ALU one cycle per command,
// captures its result and offers it downstream with valid/ready.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int unsigned W     = DefW,
  parameter int unsigned SELW  = DefSelW,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [W-1:0]    cmd_a,
  input  logic [W-1:0]    cmd_b,
  input  logic [SELW-1:0] cmd_sel,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic [SELW-1:0] alu_sel,
  output logic            alu_en,
  input  logic [W-1:0]    alu_result,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [W-1:0]    res_data,
  output logic            busy
);

  localparam int unsigned DW = 2 * W + SELW;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e          state_q, state_d;
  logic [W-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [SELW-1:0] alu_sel_q, alu_sel_d;
  logic            alu_en_q, alu_en_d;
  logic            res_valid_q, res_valid_d;
  logic [W-1:0]    res_data_q, res_data_d;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0]   fifo_rdata;
  logic [CW-1:0]   fifo_count;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;

  alu_cmd_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({cmd_a, cmd_b, cmd_sel}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state: issue from IDLE/HOLD, capture in DRIVE, hold result until accepted.
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    alu_en_d    = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    fifo_pop    = 1'b0;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop                      = 1'b1;
          {alu_a_d, alu_b_d, alu_sel_d} = fifo_rdata;
          alu_en_d                      = 1'b1;
          state_d                       = StDrive;
        end
      end
      StDrive: begin
        res_data_d  = alu_result;
        res_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop                      = 1'b1;
            {alu_a_d, alu_b_d, alu_sel_d} = fifo_rdata;
            alu_en_d                      = 1'b1;
            state_d                       = StDrive;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush wins over everything: drops queued, in-flight and held results.
    if (flush) begin
      state_d     = StIdle;
      alu_a_d     = '0;
      alu_b_d     = '0;
      alu_sel_d   = '0;
      alu_en_d    = 1'b0;
      res_valid_d = 1'b0;
      res_data_d  = '0;
      fifo_pop    = 1'b0;
    end
  end

  // State, ALU-drive and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      alu_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      alu_en_q    <= alu_en_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign alu_en    = alu_en_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = (fifo_count != '0) || (state_q != StIdle);

endmodule
